// File: rtl/mips_pipe_pkg.sv
// Shared definitions for mips_pipe_core: ISA encodings, control decode and stage-register layouts.
// With MIPS_PIPE_CORE_FWD_EN the ID/EX register also carries source register numbers for forwarding.
package mips_pipe_pkg;

    localparam int XLEN = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    jump;
        logic    alu_src;
        logic    uses_rs;
        logic    uses_rt;
        logic    dest_rd;
        alu_op_e alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_id_t;

    typedef struct packed {
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            alu_src;
        alu_op_e         alu_op;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs_val;
        logic [XLEN-1:0] rt_val;
        logic [XLEN-1:0] imm;
`ifdef MIPS_PIPE_CORE_FWD_EN
        logic [4:0]      rs;
        logic [4:0]      rt;
`endif
        logic [4:0]      dest;
    } id_ex_t;

    typedef struct packed {
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic [XLEN-1:0] alu_res;
        logic [XLEN-1:0] store_data;
        logic [4:0]      dest;
    } ex_mem_t;

    typedef struct packed {
        logic            reg_write;
        logic [XLEN-1:0] wdata;
        logic [4:0]      dest;
    } mem_wb_t;

    // Unsupported opcodes and functs decode to all-zero control, i.e. a NOP.
    function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
        ctrl_t c;
        c = '0;
        case (op)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.uses_rs   = 1'b1;
                c.uses_rt   = 1'b1;
                c.dest_rd   = 1'b1;
                case (funct)
                    FN_ADD:  c.alu_op = ALU_ADD;
                    FN_SUB:  c.alu_op = ALU_SUB;
                    FN_AND:  c.alu_op = ALU_AND;
                    FN_OR:   c.alu_op = ALU_OR;
                    FN_SLT:  c.alu_op = ALU_SLT;
                    default: c = '0;
                endcase
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.uses_rs   = 1'b1;
            end
            OP_LW: begin
                c.reg_write = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src   = 1'b1;
                c.uses_rs   = 1'b1;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.uses_rs   = 1'b1;
                c.uses_rt   = 1'b1;
            end
            OP_BEQ: begin
                c.branch  = 1'b1;
                c.uses_rs = 1'b1;
                c.uses_rt = 1'b1;
            end
            OP_J:    c.jump = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_pipe_regfile.sv
// 32x32 register file: two combinational reads, one write port, $0 hardwired to zero.
// A read of the register being written this cycle returns the incoming value.
module mips_pipe_regfile
    import mips_pipe_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [4:0]      ra1_i,
    input  logic [4:0]      ra2_i,
    output logic [XLEN-1:0] rd1_o,
    output logic [XLEN-1:0] rd2_o,
    input  logic            we_i,
    input  logic [4:0]      wa_i,
    input  logic [XLEN-1:0] wd_i
);

    logic [XLEN-1:0] regs_q [32];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != 5'd0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    always_comb begin
        rd1_o = regs_q[ra1_i];
        if (ra1_i == 5'd0) begin
            rd1_o = '0;
        end else if (we_i && (wa_i == ra1_i)) begin
            rd1_o = wd_i;
        end
    end

    always_comb begin
        rd2_o = regs_q[ra2_i];
        if (ra2_i == 5'd0) begin
            rd2_o = '0;
        end else if (we_i && (wa_i == ra2_i)) begin
            rd2_o = wd_i;
        end
    end

endmodule

// File: rtl/mips_pipe_core.sv
// Five-stage in-order MIPS-subset core (IF/ID/EX/MEM/WB) with external ROM and data RAM.
// Define MIPS_PIPE_CORE_FWD_EN for EX operand forwarding; otherwise ID stalls on any RAW hazard.
module mips_pipe_core
    import mips_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          DW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] idata,
    output logic [DW-1:0] iaddr,
    input  logic [DW-1:0] ddin,
    output logic          dwr,
    output logic [DW-1:0] daddr,
    output logic [DW-1:0] ddout
);

    logic [XLEN-1:0] pc_q, pc_d;
    if_id_t          if_id_q, if_id_d;
    id_ex_t          id_ex_q, id_ex_d;
    ex_mem_t         ex_mem_q, ex_mem_d;
    mem_wb_t         mem_wb_q, mem_wb_d;

    logic [XLEN-1:0] id_instr;
    ctrl_t           id_ctrl;
    logic [4:0]      id_rs, id_rt, id_rd, id_dest;
    logic [XLEN-1:0] id_imm, id_rs_val, id_rt_val, jump_target;
    logic            stall;

    assign id_instr    = if_id_q.instr;
    assign id_ctrl     = decode(id_instr[31:26], id_instr[5:0]);
    assign id_rs       = id_instr[25:21];
    assign id_rt       = id_instr[20:16];
    assign id_rd       = id_instr[15:11];
    assign id_imm      = {{16{id_instr[15]}}, id_instr[15:0]};
    assign jump_target = {if_id_q.pc[31:26], id_instr[25:0]};
    // A zero destination doubles as "writes nothing", which keeps hazard checks simple.
    assign id_dest     = !id_ctrl.reg_write ? 5'd0 : (id_ctrl.dest_rd ? id_rd : id_rt);

    mips_pipe_regfile u_regfile (
        .clk_i  (clk),
        .rst_ni (rst),
        .ra1_i  (id_rs),
        .ra2_i  (id_rt),
        .rd1_o  (id_rs_val),
        .rd2_o  (id_rt_val),
        .we_i   (mem_wb_q.reg_write),
        .wa_i   (mem_wb_q.dest),
        .wd_i   (mem_wb_q.wdata)
    );

    logic hit_ex;
`ifndef MIPS_PIPE_CORE_FWD_EN
    logic hit_mem;
`endif

    always_comb begin
        hit_ex = (id_ex_q.dest != 5'd0) &&
                 ((id_ctrl.uses_rs && (id_ex_q.dest == id_rs)) ||
                  (id_ctrl.uses_rt && (id_ex_q.dest == id_rt)));
`ifdef MIPS_PIPE_CORE_FWD_EN
        stall = hit_ex && id_ex_q.mem_read;
`else
        hit_mem = (ex_mem_q.dest != 5'd0) &&
                  ((id_ctrl.uses_rs && (ex_mem_q.dest == id_rs)) ||
                   (id_ctrl.uses_rt && (ex_mem_q.dest == id_rt)));
        stall = hit_ex || hit_mem;
`endif
    end

    logic [XLEN-1:0] ex_a, ex_b, ex_opb, ex_res, branch_target;
    logic            branch_taken;

    always_comb begin
        ex_a = id_ex_q.rs_val;
        ex_b = id_ex_q.rt_val;
`ifdef MIPS_PIPE_CORE_FWD_EN
        // MEM/WB first so the younger EX/MEM result overrides it.
        if ((mem_wb_q.dest != 5'd0) && (mem_wb_q.dest == id_ex_q.rs)) ex_a = mem_wb_q.wdata;
        if ((mem_wb_q.dest != 5'd0) && (mem_wb_q.dest == id_ex_q.rt)) ex_b = mem_wb_q.wdata;
        if ((ex_mem_q.dest != 5'd0) && (ex_mem_q.dest == id_ex_q.rs)) ex_a = ex_mem_q.alu_res;
        if ((ex_mem_q.dest != 5'd0) && (ex_mem_q.dest == id_ex_q.rt)) ex_b = ex_mem_q.alu_res;
`endif
    end

    always_comb begin
        ex_opb = id_ex_q.alu_src ? id_ex_q.imm : ex_b;
        case (id_ex_q.alu_op)
            ALU_ADD: ex_res = ex_a + ex_opb;
            ALU_SUB: ex_res = ex_a - ex_opb;
            ALU_AND: ex_res = ex_a & ex_opb;
            ALU_OR:  ex_res = ex_a | ex_opb;
            ALU_SLT: ex_res = {31'd0, $signed(ex_a) < $signed(ex_opb)};
            default: ex_res = '0;
        endcase
        branch_taken  = id_ex_q.branch && (ex_a == ex_b);
        branch_target = id_ex_q.pc + 32'd1 + id_ex_q.imm;
    end

    always_comb begin
        pc_d           = pc_q + 32'd1;
        if_id_d.pc     = pc_q;
        if_id_d.instr  = idata;

        id_ex_d           = '0;
        id_ex_d.reg_write = id_ctrl.reg_write;
        id_ex_d.mem_read  = id_ctrl.mem_read;
        id_ex_d.mem_write = id_ctrl.mem_write;
        id_ex_d.branch    = id_ctrl.branch;
        id_ex_d.alu_src   = id_ctrl.alu_src;
        id_ex_d.alu_op    = id_ctrl.alu_op;
        id_ex_d.pc        = if_id_q.pc;
        id_ex_d.rs_val    = id_rs_val;
        id_ex_d.rt_val    = id_rt_val;
        id_ex_d.imm       = id_imm;
`ifdef MIPS_PIPE_CORE_FWD_EN
        id_ex_d.rs        = id_rs;
        id_ex_d.rt        = id_rt;
`endif
        id_ex_d.dest      = id_dest;

        // A taken branch outranks a stall or jump: the instruction in ID is on the wrong path.
        if (branch_taken) begin
            pc_d    = branch_target;
            if_id_d = '0;
            id_ex_d = '0;
        end else if (stall) begin
            pc_d    = pc_q;
            if_id_d = if_id_q;
            id_ex_d = '0;
        end else if (id_ctrl.jump) begin
            pc_d    = jump_target;
            if_id_d = '0;
        end

        ex_mem_d.reg_write  = id_ex_q.reg_write;
        ex_mem_d.mem_read   = id_ex_q.mem_read;
        ex_mem_d.mem_write  = id_ex_q.mem_write;
        ex_mem_d.alu_res    = ex_res;
        ex_mem_d.store_data = ex_b;
        ex_mem_d.dest       = id_ex_q.dest;

        mem_wb_d.reg_write = ex_mem_q.reg_write;
        mem_wb_d.wdata     = ex_mem_q.mem_read ? ddin : ex_mem_q.alu_res;
        mem_wb_d.dest      = ex_mem_q.dest;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            if_id_q  <= '0;
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
        end else begin
            pc_q     <= pc_d;
            if_id_q  <= if_id_d;
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
        end
    end

    assign iaddr = pc_q;
    assign dwr   = ex_mem_q.mem_write;
    assign daddr = ex_mem_q.alu_res;
    assign ddout = ex_mem_q.store_data;

endmodule

// File: tb/tb_mips_pipe_core.sv
// Bench for mips_pipe_core: ROM/RAM models, an ISA-level reference interpreter that predicts
// every store, and a monitor that checks each RAM write against the expected-store queue.
module tb_mips_pipe_core;

    localparam logic [5:0] T_ADD = 6'h20, T_SUB = 6'h22, T_AND = 6'h24, T_OR = 6'h25, T_SLT = 6'h2A;
    localparam logic [5:0] T_ADDI = 6'h08, T_LW = 6'h23, T_SW = 6'h2B, T_BEQ = 6'h04;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] idata, iaddr, ddin, daddr, ddout;
    logic        dwr;

    logic [31:0] rom [64];
    logic [31:0] ram [256];
    logic [31:0] ram_init [256];
    bit          ram_load;
    logic [63:0] exp_q[$];
    int          n_vec;
    int          n_err;

    always #5 clk = ~clk;

    mips_pipe_core #(.RESET_PC(32'd0), .DW(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .idata (idata),
        .iaddr (iaddr),
        .ddin  (ddin),
        .dwr   (dwr),
        .daddr (daddr),
        .ddout (ddout)
    );

    assign idata = rom[iaddr[5:0]];
    assign ddin  = ram[daddr[7:0]];

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= ram_init[i];
        end else if (dwr) begin
            ram[daddr[7:0]] <= ddout;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write must be the next store the reference model predicted.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst === 1'b1 && dwr === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_store: got addr %h data %h expected no store", daddr, ddout);
            end else begin
                e = exp_q.pop_front();
                chk("store_addr", daddr, e[63:32]);
                chk("store_data", ddout, e[31:0]);
            end
        end
    end

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] j_ins(input int target);
        return {6'h02, 26'(target)};
    endfunction

    // Architectural interpreter: one instruction at a time, no pipeline, pushes each store.
    task automatic run_model(input int halt_idx);
        logic [31:0] r [32];
        logic [31:0] m [256];
        logic [31:0] pc, ins, a, b, imm, nxt, ad, val;
        logic [4:0]  dst;
        bit          we;
        int          steps;
        for (int i = 0; i < 32; i++) r[i] = '0;
        for (int i = 0; i < 256; i++) m[i] = ram_init[i];
        pc = '0;
        steps = 0;
        while (pc != 32'(halt_idx) && steps < 2000) begin
            ins = rom[pc[5:0]];
            a   = r[ins[25:21]];
            b   = r[ins[20:16]];
            imm = {{16{ins[15]}}, ins[15:0]};
            ad  = a + imm;
            nxt = pc + 1;
            we  = 1'b0;
            dst = '0;
            val = '0;
            case (ins[31:26])
                6'h00: begin
                    dst = ins[15:11];
                    we  = 1'b1;
                    case (ins[5:0])
                        T_ADD:   val = a + b;
                        T_SUB:   val = a - b;
                        T_AND:   val = a & b;
                        T_OR:    val = a | b;
                        T_SLT:   val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        default: we = 1'b0;
                    endcase
                end
                T_ADDI: begin dst = ins[20:16]; we = 1'b1; val = ad; end
                T_LW:   begin dst = ins[20:16]; we = 1'b1; val = m[ad[7:0]]; end
                T_SW:   begin exp_q.push_back({ad, b}); m[ad[7:0]] = b; end
                T_BEQ:  if (a == b) nxt = pc + 1 + imm;
                6'h02:  nxt = {pc[31:26], ins[25:0]};
                default: ;
            endcase
            if (we && dst != 5'd0) r[dst] = val;
            pc = nxt;
            steps++;
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = '0;
    endtask

    // Called with rst low: load RAM image, build expectations, release reset on a falling edge.
    task automatic start_prog(input int halt_idx);
        exp_q.delete();
        ram_load = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ram_load = 1'b0;
        run_model(halt_idx);
        rst = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 800) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d stores pending expected 0", name, exp_q.size());
        end
    endtask

    task automatic gen_random();
        int k, rd, rs, rt, off, tgt, lim;
        clear_rom();
        for (int r = 1; r <= 7; r++) rom[r-1] = i_ins(T_ADDI, r, 0, int'($urandom_range(0, 65535)));
        for (int i = 7; i <= 40; i++) begin
            k  = $urandom_range(0, 11);
            rd = $urandom_range(1, 15);
            rs = $urandom_range(0, 15);
            rt = $urandom_range(0, 15);
            case (k)
                0, 11: rom[i] = r_ins(T_ADD, rd, rs, rt);
                1: rom[i] = r_ins(T_SUB, rd, rs, rt);
                2: rom[i] = r_ins(T_AND, rd, rs, rt);
                3: rom[i] = r_ins(T_OR, rd, rs, rt);
                4: rom[i] = r_ins(T_SLT, rd, rs, rt);
                5: rom[i] = i_ins(T_ADDI, rd, rs, int'($urandom_range(0, 65535)));
                6: rom[i] = i_ins(T_LW, rd, rs, int'($urandom_range(0, 15)));
                7: rom[i] = i_ins(T_SW, rt, rs, int'($urandom_range(0, 15)));
                8: begin
                    lim = (40 - i < 3) ? 40 - i : 3;
                    off = $urandom_range(0, lim);
                    if ($urandom_range(0, 1) == 1) rt = rs;
                    rom[i] = i_ins(T_BEQ, rt, rs, off);
                end
                9: begin
                    lim = (i + 4 > 41) ? 41 : i + 4;
                    tgt = $urandom_range(i + 1, lim);
                    rom[i] = j_ins(tgt);
                end
                default: rom[i] = (rs[0]) ? {6'h3F, 26'($urandom)} : r_ins(6'h00, rd, rs, rt);
            endcase
        end
        for (int r = 1; r <= 15; r++) rom[40 + r] = i_ins(T_SW, r, 0, 8'h80 + r);
        rom[56] = j_ins(56);
        for (int i = 0; i < 256; i++) ram_init[i] = (i < 16) ? $urandom : 32'd0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst      = 1'b0;
        ram_load = 1'b0;
        clear_rom();
        for (int i = 0; i < 256; i++) ram_init[i] = '0;

        // Reset state and free-running fetch over an all-zero ROM.
        repeat (3) @(negedge clk);
        chk("rst_iaddr", iaddr, 32'd0);
        chk("rst_dwr", {31'd0, dwr}, 32'd0);
        chk("rst_daddr", daddr, 32'd0);
        chk("rst_ddout", ddout, 32'd0);
        start_prog(0);
        #1;
        chk("fetch_0", iaddr, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk("fetch_seq", iaddr, 32'(k));
            chk("zero_rom_dwr", {31'd0, dwr}, 32'd0);
        end

        // Randomized programs.
        for (int p = 0; p < 10; p++) begin
            @(negedge clk);
            rst = 1'b0;
            gen_random();
            start_prog(56);
            wait_done("random");
        end

        // Reset asserted mid-run, then the same program from a clean start.
        @(negedge clk);
        rst = 1'b0;
        gen_random();
        start_prog(56);
        repeat (25) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_iaddr", iaddr, 32'd0);
        chk("midrst_dwr", {31'd0, dwr}, 32'd0);
        chk("midrst_daddr", daddr, 32'd0);
        chk("midrst_ddout", ddout, 32'd0);
        @(negedge clk);
        start_prog(56);
        wait_done("restart");

        // Directed: forwarding chain, load-use, $0, SLT, wrap, BEQ shadow, cleared register.
        @(negedge clk);
        rst = 1'b0;
        clear_rom();
        rom[0]  = i_ins(T_ADDI, 1, 0, 5);
        rom[1]  = r_ins(T_ADD, 2, 1, 1);
        rom[2]  = r_ins(T_SUB, 3, 2, 1);
        rom[3]  = i_ins(T_SW, 2, 0, 16'h40);
        rom[4]  = i_ins(T_SW, 3, 0, 16'h41);
        rom[5]  = i_ins(T_SW, 3, 0, 0);
        rom[6]  = i_ins(T_LW, 4, 0, 0);
        rom[7]  = r_ins(T_ADD, 5, 4, 4);
        rom[8]  = i_ins(T_SW, 5, 0, 16'h42);
        rom[9]  = r_ins(T_ADD, 0, 1, 1);
        rom[10] = i_ins(T_SW, 0, 0, 16'h43);
        rom[11] = i_ins(T_ADDI, 9, 0, -1);
        rom[12] = i_ins(T_ADDI, 10, 0, 1);
        rom[13] = r_ins(T_SLT, 8, 9, 10);
        rom[14] = i_ins(T_SW, 8, 0, 16'h44);
        rom[15] = i_ins(T_LW, 11, 0, 16'h30);
        rom[16] = i_ins(T_ADDI, 12, 11, 1);
        rom[17] = i_ins(T_SW, 12, 0, 16'h45);
        rom[18] = i_ins(T_BEQ, 1, 1, 2);
        rom[19] = i_ins(T_ADDI, 6, 0, 1);
        rom[20] = i_ins(T_ADDI, 6, 0, 1);
        rom[21] = i_ins(T_SW, 6, 0, 16'h46);
        rom[22] = i_ins(T_SW, 13, 0, 16'h47);
        rom[23] = j_ins(23);
        for (int i = 0; i < 256; i++) ram_init[i] = '0;
        ram_init[8'h30] = 32'h7FFF_FFFF;
        start_prog(23);
        wait_done("directed");

        // Directed: J with a shadow slot and redirect timing.
        @(negedge clk);
        rst = 1'b0;
        clear_rom();
        rom[0]     = j_ins(16'h10);
        rom[1]     = i_ins(T_ADDI, 7, 0, 9);
        rom[16'h10] = i_ins(T_SW, 7, 0, 16'h20);
        rom[16'h11] = i_ins(T_ADDI, 7, 0, 3);
        rom[16'h12] = i_ins(T_SW, 7, 0, 16'h21);
        rom[16'h13] = j_ins(16'h13);
        for (int i = 0; i < 256; i++) ram_init[i] = '0;
        start_prog(16'h13);
        #1;
        chk("j_fetch", iaddr, 32'd0);
        @(negedge clk);
        chk("j_shadow", iaddr, 32'd1);
        @(negedge clk);
        chk("j_target", iaddr, 32'h10);
        wait_done("jump");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
